// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver, with a sticky overflow flag.
// Optional almost_full output is enabled by defining RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
`ifdef RX_FIFO_ALMOST_FULL_EN
  parameter int AF_LVL = 12,
`endif
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   din,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic [DBIT-1:0]   dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
`ifdef RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DBIT-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rdEn, wrEn;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dout     = empty ? '0 : mem[rdPtr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write when popped.
  always_comb begin
    rdEn       = rd && !empty;
    wrEn       = rx_done_tick && (!full || rdEn);
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wrEn) wrPtr_d = wrPtr_q + ADDR_W'(1);
    if (rdEn) rdPtr_d = rdPtr_q + ADDR_W'(1);
    if (wrEn && !rdEn) count_d = count_q + (ADDR_W+1)'(1);
    else if (rdEn && !wrEn) count_d = count_q - (ADDR_W+1)'(1);
    if (rx_done_tick && full && !rd) overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q] <= din;
  end

`ifdef RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_CNT = AF_LVL[ADDR_W:0];
  logic almostFull_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) almostFull_q <= 1'b0;
    else        almostFull_q <= (count_d >= AF_CNT);
  end

  assign almost_full = almostFull_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick, rd, clr_ovf;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty, full, overflow;
  logic [4:0] count;
`ifdef RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int passCount  = 0;
  int totalCount = 0;
  bit checkEn    = 1'b0;

  byte unsigned modelQ[$];
  bit           modelOvf = 1'b0;
  bit           modelAf  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .din         (din),
    .rd          (rd),
    .clr_ovf     (clr_ovf),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
`ifdef RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: a 16-entry queue updated from the rules on each accepted edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelAf  = 1'b0;
    end else begin
      bit wasFull, popOk;
      wasFull = (modelQ.size() == 16);
      popOk   = rd && (modelQ.size() > 0);
      if (rx_done_tick && wasFull && !rd) modelOvf = 1'b1;
      else if (clr_ovf) modelOvf = 1'b0;
      if (popOk) void'(modelQ.pop_front());
      if (rx_done_tick && (!wasFull || popOk)) modelQ.push_back(din);
      modelAf = (modelQ.size() >= 12);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc.dout", int'(dout), (modelQ.size() > 0) ? int'(modelQ[0]) : 0);
      checkOutput("cyc.count", int'(count), modelQ.size());
      checkOutput("cyc.empty", int'(empty), int'(modelQ.size() == 0));
      checkOutput("cyc.full", int'(full), int'(modelQ.size() == 16));
      checkOutput("cyc.overflow", int'(overflow), int'(modelOvf));
`ifdef RX_FIFO_ALMOST_FULL_EN
      checkOutput("cyc.almost_full", int'(almost_full), int'(modelAf));
`endif
    end
  end

  // Drives one cycle of inputs; they are sampled on the following rising edge.
  task automatic applyStimulus(input bit wr, input byte unsigned data, input bit pop, input bit clr);
    @(posedge clk);
    #1;
    rx_done_tick = wr;
    din          = data;
    rd           = pop;
    clr_ovf      = clr;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    rx_done_tick = 1'b0;
    din = 8'h00;
    rd = 1'b0;
    clr_ovf = 1'b0;
    #12;
    checkOutput("reset.empty", int'(empty), 1);
    checkOutput("reset.count", int'(count), 0);
    checkOutput("reset.dout", int'(dout), 0);
    checkOutput("reset.overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkEn = 1'b1;

    // Two writes, then one pop
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyIdle();
    checkOutput("t2.dout0", int'(dout), 8'hA5);
    checkOutput("t2.count0", int'(count), 2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyIdle();
    checkOutput("t2.dout1", int'(dout), 8'h3C);
    checkOutput("t2.count1", int'(count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyIdle();

    // Fill, overflow, drain in order, clear overflow
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyIdle();
    checkOutput("t3.full", int'(full), 1);
    checkOutput("t3.count", int'(count), 16);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    applyIdle();
    checkOutput("t3.overflow", int'(overflow), 1);
    checkOutput("t3.countAfterDrop", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t3.drain", int'(dout), i);
    end
    applyIdle();
    checkOutput("t3.empty", int'(empty), 1);
    checkOutput("t3.overflowHeld", int'(overflow), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyIdle();
    checkOutput("t3.clr", int'(overflow), 0);

    // Full FIFO with simultaneous write and pop
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    applyIdle();
    checkOutput("t4.count", int'(count), 16);
    checkOutput("t4.overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t4.drain", int'(dout), (i == 15) ? 8'h77 : 8'h11 + i);
    end
    applyIdle();

    // Empty FIFO: simultaneous pop+write, then pop alone
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    applyIdle();
    checkOutput("t5.count", int'(count), 1);
    checkOutput("t5.dout", int'(dout), 8'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyIdle();
    checkOutput("t5.emptyPop", int'(count), 0);
    checkOutput("t5.emptyFlag", int'(empty), 1);

    // Interleaved write/read pairs crossing the pointer wrap
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 8'(k * 7 + 3), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t6.wrap", int'(dout), (k * 7 + 3) & 8'hFF);
    end
    applyIdle();
    checkOutput("t6.empty", int'(empty), 1);

`ifdef RX_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyIdle();
    checkOutput("t6.af11", int'(almost_full), 0);
    applyStimulus(1'b1, 8'h4B, 1'b0, 1'b0);
    applyIdle();
    checkOutput("t6.af12", int'(almost_full), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyIdle();
    checkOutput("t6.afPop", int'(almost_full), 0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyIdle();
`endif

    // Asynchronous reset in the middle of traffic with overflow set
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t1.empty", int'(empty), 1);
    checkOutput("t1.count", int'(count), 0);
    checkOutput("t1.dout", int'(dout), 0);
    checkOutput("t1.overflow", int'(overflow), 0);
    applyIdle();
    reset = 1'b1;
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    applyIdle();
    checkOutput("t1.afterDout", int'(dout), 8'hC3);
    checkOutput("t1.afterCount", int'(count), 1);
    applyIdle();

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
